csr_regfile: RTL and testbench



---
 rtl/sys_pkg.sv | 29 ++
 rtl/csr_counter64.sv | 34 +++
 rtl/csr_regfile.sv | 100 ++++++++++
 tb/tb_csr_regfile.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/sys_pkg.sv
// Shared SYS definitions: CSR index map, architectural addresses and WARL masks
// used by the machine-mode CSR register file.
package sys_pkg;

    typedef enum logic [2:0] {
        CSR_MCAUSE   = 3'd0,
        CSR_MSTATUS  = 3'd1,
        CSR_MEPC     = 3'd2,
        CSR_MTVEC    = 3'd3,
        CSR_MCYCLE   = 3'd4,
        CSR_MINSTRET = 3'd5
    } csr_idx_e;

    localparam logic [11:0] CSR_ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_ADDR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_ADDR_MINSTRET = 12'hB02;

    // UXL/SXL = 2, MPP = 3
    localparam logic [63:0] SYS_MSTATUS_RST = 64'h0000_000a_0000_1800;

    // Set bits are read-only in mstatus (UXL/SXL fields)
    localparam logic [63:0] MSTATUS_RO_MASK = 64'h0000_000f_0000_0000;
    localparam logic [63:0] MEPC_WMASK      = 64'hFFFF_FFFF_FFFF_FFFE;
    localparam logic [63:0] MTVEC_WMASK     = 64'hFFFF_FFFF_FFFF_FFFC;

endpackage

// File: rtl/csr_counter64.sv
// Loadable free-running counter; a load in the same cycle overrides the increment.
module csr_counter64 #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR storage: combinational read with no bypass, WARL-filtered
// writes committed at the clock edge, plus mcycle/minstret counters.
module csr_regfile
    import sys_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 3,
    parameter int                    DATA_WIDTH  = 64,
    parameter logic [DATA_WIDTH-1:0] MSTATUS_RST = SYS_MSTATUS_RST
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] csrf_raddr,
    output logic [DATA_WIDTH-1:0] csrf_rdata,
    input  logic [ADDR_WIDTH-1:0] csrf_waddr,
    input  logic [DATA_WIDTH-1:0] csrf_wdata,
    input  logic                  csrf_wen,
    input  logic                  retire,
    output logic                  rd_illegal,
    output logic [DATA_WIDTH-1:0] mtvec_o,
    output logic [DATA_WIDTH-1:0] mepc_o
);

    localparam logic [DATA_WIDTH-1:0] RO_MASK  = DATA_WIDTH'(MSTATUS_RO_MASK);
    localparam logic [DATA_WIDTH-1:0] EPC_MASK = DATA_WIDTH'(MEPC_WMASK);
    localparam logic [DATA_WIDTH-1:0] TVC_MASK = DATA_WIDTH'(MTVEC_WMASK);

    logic [DATA_WIDTH-1:0] mcause_q, mcause_d;
    logic [DATA_WIDTH-1:0] mstatus_q, mstatus_d;
    logic [DATA_WIDTH-1:0] mepc_q, mepc_d;
    logic [DATA_WIDTH-1:0] mtvec_q, mtvec_d;
    logic [DATA_WIDTH-1:0] mcycle, minstret;

    logic we_mcause, we_mstatus, we_mepc, we_mtvec, we_mcycle, we_minstret;

    assign we_mcause   = csrf_wen && (csrf_waddr == ADDR_WIDTH'(CSR_MCAUSE));
    assign we_mstatus  = csrf_wen && (csrf_waddr == ADDR_WIDTH'(CSR_MSTATUS));
    assign we_mepc     = csrf_wen && (csrf_waddr == ADDR_WIDTH'(CSR_MEPC));
    assign we_mtvec    = csrf_wen && (csrf_waddr == ADDR_WIDTH'(CSR_MTVEC));
    assign we_mcycle   = csrf_wen && (csrf_waddr == ADDR_WIDTH'(CSR_MCYCLE));
    assign we_minstret = csrf_wen && (csrf_waddr == ADDR_WIDTH'(CSR_MINSTRET));

    always_comb begin
        mcause_d  = we_mcause  ? csrf_wdata : mcause_q;
        mstatus_d = we_mstatus ? ((csrf_wdata & ~RO_MASK) | (MSTATUS_RST & RO_MASK))
                               : mstatus_q;
        mepc_d    = we_mepc    ? (csrf_wdata & EPC_MASK) : mepc_q;
        mtvec_d   = we_mtvec   ? (csrf_wdata & TVC_MASK) : mtvec_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcause_q  <= '0;
            mstatus_q <= MSTATUS_RST;
            mepc_q    <= '0;
            mtvec_q   <= '0;
        end else begin
            mcause_q  <= mcause_d;
            mstatus_q <= mstatus_d;
            mepc_q    <= mepc_d;
            mtvec_q   <= mtvec_d;
        end
    end

    csr_counter64 #(.W(DATA_WIDTH)) u_mcycle (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (1'b1),
        .load_i     (we_mcycle),
        .load_val_i (csrf_wdata),
        .cnt_o      (mcycle)
    );

    csr_counter64 #(.W(DATA_WIDTH)) u_minstret (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (retire),
        .load_i     (we_minstret),
        .load_val_i (csrf_wdata),
        .cnt_o      (minstret)
    );

    // Reads see register state only, so a write in flight is never forwarded
    always_comb begin
        csrf_rdata = '0;
        rd_illegal = 1'b0;
        case (csrf_raddr)
            ADDR_WIDTH'(CSR_MCAUSE):   csrf_rdata = mcause_q;
            ADDR_WIDTH'(CSR_MSTATUS):  csrf_rdata = mstatus_q;
            ADDR_WIDTH'(CSR_MEPC):     csrf_rdata = mepc_q;
            ADDR_WIDTH'(CSR_MTVEC):    csrf_rdata = mtvec_q;
            ADDR_WIDTH'(CSR_MCYCLE):   csrf_rdata = mcycle;
            ADDR_WIDTH'(CSR_MINSTRET): csrf_rdata = minstret;
            default:                   rd_illegal = 1'b1;
        endcase
    end

    assign mtvec_o = mtvec_q;
    assign mepc_o  = mepc_q;

endmodule

// File: tb/tb_csr_regfile.sv
// Directed-vector bench for csr_regfile with hand-computed expected values.
module tb_csr_regfile;

    logic        clk;
    logic        rst;
    logic [2:0]  csrf_raddr;
    logic [63:0] csrf_rdata;
    logic [2:0]  csrf_waddr;
    logic [63:0] csrf_wdata;
    logic        csrf_wen;
    logic        retire;
    logic        rd_illegal;
    logic [63:0] mtvec_o;
    logic [63:0] mepc_o;

    int          n_vec;
    int          n_mis;
    logic [63:0] exp_cyc;

    localparam logic [63:0] MST_RST = 64'h0000_000a_0000_1800;

    csr_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .csrf_raddr (csrf_raddr),
        .csrf_rdata (csrf_rdata),
        .csrf_waddr (csrf_waddr),
        .csrf_wdata (csrf_wdata),
        .csrf_wen   (csrf_wen),
        .retire     (retire),
        .rd_illegal (rd_illegal),
        .mtvec_o    (mtvec_o),
        .mepc_o     (mepc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Advance one clock; the mcycle model follows reset > write > increment.
    task automatic step();
        if (rst) exp_cyc = 64'd0;
        else if (csrf_wen && csrf_waddr == 3'd4) exp_cyc = csrf_wdata;
        else exp_cyc = exp_cyc + 64'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [2:0] idx, input string tag, input logic [63:0] exp);
        csrf_raddr = idx;
        #1;
        chk(tag, csrf_rdata, exp);
    endtask

    task automatic wr(input logic [2:0] idx, input logic [63:0] val);
        csrf_wen   = 1'b1;
        csrf_waddr = idx;
        csrf_wdata = val;
        step();
        csrf_wen   = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_mis = 0; exp_cyc = 64'd0;
        rst = 1'b1; csrf_raddr = '0; csrf_waddr = '0; csrf_wdata = '0;
        csrf_wen = 1'b0; retire = 1'b0;
        #1;
        step();
        step();
        rst = 1'b0;

        rd(3'd0, "rst_mcause", 64'd0);
        rd(3'd1, "rst_mstatus", MST_RST);
        rd(3'd2, "rst_mepc", 64'd0);
        rd(3'd3, "rst_mtvec", 64'd0);
        rd(3'd4, "rst_mcycle", 64'd0);
        rd(3'd5, "rst_minstret", 64'd0);
        chk("rst_mtvec_o", mtvec_o, 64'd0);
        chk("rst_mepc_o", mepc_o, 64'd0);

        wr(3'd3, 64'h8000_0103);
        rd(3'd3, "warl_mtvec", 64'h8000_0100);
        chk("warl_mtvec_o", mtvec_o, 64'h8000_0100);
        wr(3'd2, 64'h8000_0011);
        rd(3'd2, "warl_mepc", 64'h8000_0010);
        chk("warl_mepc_o", mepc_o, 64'h8000_0010);
        wr(3'd1, 64'd0);
        rd(3'd1, "warl_mstatus0", 64'h0000_000a_0000_0000);
        wr(3'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(3'd1, "warl_mstatus1", 64'hFFFF_FFFA_FFFF_FFFF);
        wr(3'd0, 64'hDEAD_BEEF_0123_4567);
        rd(3'd0, "mcause_full", 64'hDEAD_BEEF_0123_4567);

        wr(3'd0, 64'h5);
        csrf_wen = 1'b1; csrf_waddr = 3'd0; csrf_wdata = 64'hb;
        rd(3'd0, "rdw_old", 64'h5);
        step();
        csrf_wen = 1'b0;
        rd(3'd0, "rdw_new", 64'hb);

        wr(3'd4, 64'hFFFF_FFFF_FFFF_FFFE);
        rd(3'd4, "mcycle_load", 64'hFFFF_FFFF_FFFF_FFFE);
        step();
        rd(3'd4, "mcycle_max", 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        rd(3'd4, "mcycle_wrap", 64'd0);
        step();
        rd(3'd4, "mcycle_inc", 64'd1);

        retire = 1'b1;
        wr(3'd5, 64'd100);
        retire = 1'b0;
        rd(3'd5, "minstret_wr_wins", 64'd100);
        step();
        rd(3'd5, "minstret_idle", 64'd100);
        retire = 1'b1;
        step();
        retire = 1'b0;
        rd(3'd5, "minstret_retire", 64'd101);
        wr(3'd5, 64'hFFFF_FFFF_FFFF_FFFF);
        retire = 1'b1;
        step();
        retire = 1'b0;
        rd(3'd5, "minstret_wrap", 64'd0);
        wr(3'd5, 64'd101);

        rd(3'd6, "illegal6_data", 64'd0);
        chk("illegal6_flag", {63'd0, rd_illegal}, 64'd1);
        rd(3'd7, "illegal7_data", 64'd0);
        chk("illegal7_flag", {63'd0, rd_illegal}, 64'd1);
        rd(3'd5, "legal5_data", 64'd101);
        chk("legal5_flag", {63'd0, rd_illegal}, 64'd0);

        wr(3'd7, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(3'd0, "w7_mcause", 64'hb);
        rd(3'd1, "w7_mstatus", 64'hFFFF_FFFA_FFFF_FFFF);
        rd(3'd2, "w7_mepc", 64'h8000_0010);
        rd(3'd3, "w7_mtvec", 64'h8000_0100);
        rd(3'd4, "w7_mcycle", exp_cyc);
        rd(3'd5, "w7_minstret", 64'd101);

        rst = 1'b1; retire = 1'b1;
        csrf_wen = 1'b1; csrf_waddr = 3'd3; csrf_wdata = 64'h1234_5678;
        step();
        rst = 1'b0; retire = 1'b0; csrf_wen = 1'b0;
        rd(3'd3, "mid_rst_mtvec", 64'd0);
        chk("mid_rst_mtvec_o", mtvec_o, 64'd0);
        rd(3'd5, "mid_rst_minstret", 64'd0);
        rd(3'd1, "mid_rst_mstatus", MST_RST);
        rd(3'd4, "mid_rst_mcycle", 64'd0);
        rd(3'd2, "mid_rst_mepc", 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
